// File: rtl/fft_sched_pkg.sv
// Shared state encoding, default sizing and address helpers for the FFT butterfly scheduler.
package fft_sched_pkg;

    localparam int DEFAULT_LOG2N    = 4;
    localparam int DEFAULT_PIPE_LAT = 2;
    localparam int MAX_LOG2N        = 10;

    typedef logic [MAX_LOG2N-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    function automatic addr_t half_mask(input int unsigned s);
        return addr_t'((32'd1 << s) - 32'd1);
    endfunction

    // Group index moves up one bit to skip over the B half of each group.
    function automatic addr_t bfly_addr_a(input int unsigned s, input addr_t k);
        return ((k >> s) << (s + 32'd1)) | (k & half_mask(s));
    endfunction

    function automatic addr_t bfly_addr_b(input int unsigned s, input addr_t k);
        return bfly_addr_a(s, k) | addr_t'(32'd1 << s);
    endfunction

    function automatic addr_t twiddle_index(input int unsigned log2n, input int unsigned s,
                                            input addr_t k);
        return (k & half_mask(s)) << (log2n - 32'd1 - s);
    endfunction

endpackage

// File: rtl/fft_addr_pipe.sv
// Write-back delay line: carries butterfly destination addresses alongside the data pipeline.
module fft_addr_pipe #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         freeze,
    input  logic         valid,
    input  logic [W-1:0] addr_a,
    input  logic [W-1:0] addr_b,
    output logic         tail_valid,
    output logic [W-1:0] tail_addr_a,
    output logic [W-1:0] tail_addr_b
);

    logic [DEPTH-1:0] valid_r;
    logic [W-1:0]     addr_a_r [DEPTH];
    logic [W-1:0]     addr_b_r [DEPTH];

    // Shift register; a frozen cycle holds every stage so stalls neither drop nor repeat writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_a_r[i] <= '0;
                addr_b_r[i] <= '0;
            end
        end else if (!freeze) begin
            valid_r[0]  <= valid;
            addr_a_r[0] <= addr_a;
            addr_b_r[0] <= addr_b;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i]  <= valid_r[i-1];
                addr_a_r[i] <= addr_a_r[i-1];
                addr_b_r[i] <= addr_b_r[i-1];
            end
        end
    end

    assign tail_valid  = valid_r[DEPTH-1];
    assign tail_addr_a = addr_a_r[DEPTH-1];
    assign tail_addr_b = addr_b_r[DEPTH-1];

endmodule

// File: rtl/fft_bfly_scheduler.sv
// In-place radix-2 DIT FFT butterfly sequencer with per-stage pipeline drain.
// Optional IFFT support (inverse / tw_conj / scale_en) when FFT_SCHED_INVERSE_EN is defined.
module fft_bfly_scheduler
    import fft_sched_pkg::*;
#(
    parameter int LOG2N    = DEFAULT_LOG2N,
    parameter int PIPE_LAT = DEFAULT_PIPE_LAT
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef FFT_SCHED_INVERSE_EN
    input  logic                     inverse,
    output logic                     tw_conj,
    output logic                     scale_en,
`endif
    input  logic                     start,
    input  logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [LOG2N-1:0]         rd_addr_a,
    output logic [LOG2N-1:0]         rd_addr_b,
    output logic [LOG2N-2:0]         tw_addr,
    output logic                     wr_en,
    output logic [LOG2N-1:0]         wr_addr_a,
    output logic [LOG2N-1:0]         wr_addr_b,
    output logic [$clog2(LOG2N)-1:0] stage
);

    localparam int SW = $clog2(LOG2N);
    localparam int KW = LOG2N - 1;
    localparam int DW = 2;
    localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
    localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

    state_e         state_r, state_nxt_s;
    logic [SW-1:0]  s_r, s_nxt_s;
    logic [KW-1:0]  k_r, k_nxt_s;
    logic [DW-1:0]  d_r, d_nxt_s;

    logic             rd_en_r, rd_en_s, busy_r, busy_s, done_r, done_s, tail_valid_s, wr_en_s;
    logic [LOG2N-1:0] rd_addr_a_r, rd_addr_a_s, rd_addr_b_r, rd_addr_b_s;
    logic [KW-1:0]    tw_addr_r, tw_addr_s;

`ifdef FFT_SCHED_INVERSE_EN
    logic accept_s, inv_r, inv_nxt_s, tw_conj_r;
`endif

    // Next-state: ready low freezes the sequencer exactly where it is.
    always_comb begin
        state_nxt_s = state_r;
        s_nxt_s     = s_r;
        k_nxt_s     = k_r;
        d_nxt_s     = d_r;
        if (ready) begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s = ST_RUN;
                        s_nxt_s     = '0;
                        k_nxt_s     = '0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (k_r == K_LAST) begin
                        state_nxt_s = ST_DRAIN;
                        d_nxt_s     = '0;
                    end else begin
                        k_nxt_s = k_r + KW'(1'b1);
                    end
                end
                ST_DRAIN: begin
                    if (d_r != D_LAST) begin
                        d_nxt_s = d_r + DW'(1'b1);
                    end else if (s_r == S_LAST) begin
                        state_nxt_s = ST_FIN;
                    end else begin
                        state_nxt_s = ST_RUN;
                        s_nxt_s     = s_r + SW'(1'b1);
                        k_nxt_s     = '0;
                    end
                end
                ST_FIN: begin
                    state_nxt_s = ST_IDLE;
                    s_nxt_s     = '0;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    s_nxt_s     = '0;
                    k_nxt_s     = '0;
                    d_nxt_s     = '0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output decode from the next state so every strobe and address leaves a flop.
    always_comb begin
        busy_s = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
        done_s = (state_nxt_s == ST_FIN);
        if (state_nxt_s == ST_RUN) begin
            rd_en_s     = 1'b1;
            rd_addr_a_s = LOG2N'(bfly_addr_a(32'(s_nxt_s), addr_t'(k_nxt_s)));
            rd_addr_b_s = LOG2N'(bfly_addr_b(32'(s_nxt_s), addr_t'(k_nxt_s)));
            tw_addr_s   = KW'(twiddle_index(LOG2N, 32'(s_nxt_s), addr_t'(k_nxt_s)));
        end else begin
            rd_en_s     = 1'b0;
            rd_addr_a_s = '0;
            rd_addr_b_s = '0;
            tw_addr_s   = '0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            s_r         <= '0;
            k_r         <= '0;
            d_r         <= '0;
            rd_en_r     <= 1'b0;
            rd_addr_a_r <= '0;
            rd_addr_b_r <= '0;
            tw_addr_r   <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            s_r         <= s_nxt_s;
            k_r         <= k_nxt_s;
            d_r         <= d_nxt_s;
            rd_en_r     <= rd_en_s;
            rd_addr_a_r <= rd_addr_a_s;
            rd_addr_b_r <= rd_addr_b_s;
            tw_addr_r   <= tw_addr_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    fft_addr_pipe #(
        .W     (LOG2N),
        .DEPTH (PIPE_LAT)
    ) u_addr_pipe (
        .clk         (clk),
        .rst         (rst),
        .freeze      (!ready),
        .valid       (rd_en_r),
        .addr_a      (rd_addr_a_r),
        .addr_b      (rd_addr_b_r),
        .tail_valid  (tail_valid_s),
        .tail_addr_a (wr_addr_a),
        .tail_addr_b (wr_addr_b)
    );

    assign wr_en_s   = tail_valid_s & ready;
    assign wr_en     = wr_en_s;
    assign rd_en     = rd_en_r & ready;
    assign rd_addr_a = rd_addr_a_r;
    assign rd_addr_b = rd_addr_b_r;
    assign tw_addr   = tw_addr_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign stage     = s_r;

`ifdef FFT_SCHED_INVERSE_EN
    assign accept_s = ready && start && (state_r == ST_IDLE);

    // Direction is latched on acceptance and ignored for the rest of the run.
    always_comb begin
        if (accept_s) begin
            inv_nxt_s = inverse;
        end else begin
            inv_nxt_s = inv_r;
        end
    end

    // Direction register and conjugate flag aligned with tw_addr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_r     <= 1'b0;
            tw_conj_r <= 1'b0;
        end else begin
            inv_r     <= inv_nxt_s;
            tw_conj_r <= inv_nxt_s && (state_nxt_s == ST_RUN);
        end
    end

    assign tw_conj  = tw_conj_r;
    assign scale_en = wr_en_s & inv_r;
`endif

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// Self-checking bench for fft_bfly_scheduler (LOG2N=4, PIPE_LAT=2).
module tb_fft_bfly_scheduler;

    localparam int LOG2N     = 4;
    localparam int PL        = 2;
    localparam int N         = 1 << LOG2N;
    localparam int HALF_N    = N / 2;
    localparam int STAGE_LEN = HALF_N + PL;
    localparam int TOTAL     = LOG2N * STAGE_LEN;
    localparam int SW        = $clog2(LOG2N);

    logic             clk = 1'b0;
    logic             rst, start, ready;
    logic             busy, done, rd_en, wr_en;
    logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [LOG2N-2:0] tw_addr;
    logic [SW-1:0]    stage;
`ifdef FFT_SCHED_INVERSE_EN
    logic             inverse, tw_conj, scale_en;
`endif

    always #5 clk = ~clk;

    fft_bfly_scheduler #(.LOG2N(LOG2N), .PIPE_LAT(PL)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef FFT_SCHED_INVERSE_EN
        .inverse   (inverse),
        .tw_conj   (tw_conj),
        .scale_en  (scale_en),
`endif
        .start     (start),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .stage     (stage)
    );

    typedef struct { int s; int k; int a; int b; int tw; } addr_vec_t;
    typedef struct { int stall_at; int stall_len; int rnd_stall; int stray; int inv; int exp_done; } run_vec_t;

    int   errors = 0;
    int   checks = 0;
    int   ref_a  [LOG2N][HALF_N];
    int   ref_b  [LOG2N][HALF_N];
    int   ref_tw [LOG2N][HALF_N];
    int   obs_a  [LOG2N][HALF_N];
    int   obs_b  [LOG2N][HALF_N];
    int   obs_tw [LOG2N][HALF_N];
    logic cur_inv = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // e = ready-high edges since the start was accepted; the whole schedule follows from it.
    task automatic check_outputs(input int e, input logic rdy);
        int   j, s, r;
        logic rdv, wrv;
        if (e >= 1 && e <= TOTAL) begin
            j   = e - 1;
            s   = j / STAGE_LEN;
            r   = j % STAGE_LEN;
            rdv = (r < HALF_N);
            wrv = (r >= PL) && (r < HALF_N + PL);
            chk("busy_run", busy, 32'd1);
            chk("done_run", done, 32'd0);
            chk("rd_en", rd_en, rdv & rdy);
            chk("wr_en", wr_en, wrv & rdy);
            chk("stage", stage, s);
            if (rdv) begin
                chk("rd_addr_a", rd_addr_a, ref_a[s][r]);
                chk("rd_addr_b", rd_addr_b, ref_b[s][r]);
                chk("tw_addr", tw_addr, ref_tw[s][r]);
                obs_a[s][r]  = int'(rd_addr_a);
                obs_b[s][r]  = int'(rd_addr_b);
                obs_tw[s][r] = int'(tw_addr);
            end
            if (wrv) begin
                chk("wr_addr_a", wr_addr_a, ref_a[s][r-PL]);
                chk("wr_addr_b", wr_addr_b, ref_b[s][r-PL]);
            end
`ifdef FFT_SCHED_INVERSE_EN
            if (rdv) chk("tw_conj", tw_conj, cur_inv);
            chk("scale_en", scale_en, wrv & rdy & cur_inv);
`endif
        end else if (e == TOTAL + 1) begin
            chk("done_pulse", done, 32'd1);
            chk("busy_fin", busy, 32'd0);
            chk("rd_en_fin", rd_en, 32'd0);
            chk("wr_en_fin", wr_en, 32'd0);
        end else begin
            chk("busy_idle", busy, 32'd0);
            chk("done_idle", done, 32'd0);
            chk("rd_en_idle", rd_en, 32'd0);
            chk("wr_en_idle", wr_en, 32'd0);
        end
    endtask

    // One FFT from its start cycle (c=0) through the done cycle; starts at posedge+1.
    task automatic do_run(input run_vec_t v, output int done_cyc, output int n_rd, output int n_wr);
        int   e   = 0;
        bit   fin = 1'b0;
        logic rdy_now;
        done_cyc = -1;
        n_rd     = 0;
        n_wr     = 0;
        cur_inv  = v.inv[0];
        for (int c = 0; c < 400 && !fin; c++) begin
            if (c == 0) begin
                start   = 1'b1;
                rdy_now = 1'b1;
            end else begin
                if (e == TOTAL + 1) rdy_now = 1'b1;
                else if (c >= v.stall_at && c < v.stall_at + v.stall_len) rdy_now = 1'b0;
                else if (v.rnd_stall != 0 && $urandom_range(0, 3) == 0) rdy_now = 1'b0;
                else rdy_now = 1'b1;
                if (v.stray == 1) start = (c == 5) || (e == TOTAL + 1);
                else if (v.stray == 2) start = ($urandom_range(0, 5) == 0);
                else start = 1'b0;
            end
`ifdef FFT_SCHED_INVERSE_EN
            inverse = (c == 0) ? cur_inv : 1'($urandom_range(0, 1));
`endif
            ready = rdy_now;
            @(negedge clk);
            check_outputs(e, rdy_now);
            n_rd += int'(rd_en);
            n_wr += int'(wr_en);
            if (done) done_cyc = c;
            if (e == TOTAL + 1) fin = 1'b1;
            if (rdy_now) e++;
            @(posedge clk);
            #1;
        end
        chk("run_finished", fin, 32'd1);
        start = 1'b0;
        ready = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_outputs(0, ready);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        addr_vec_t avec [6];
        run_vec_t  runs [5];
        run_vec_t  rv;
        int        dc, nr, nw, d1, d2, done_seen;

        // Butterfly order from the textbook nested group/position loops.
        for (int s = 0; s < LOG2N; s++) begin
            for (int g = 0; g < N / (2 << s); g++) begin
                for (int p = 0; p < (1 << s); p++) begin
                    ref_a[s][g*(1<<s)+p]  = g * (2 << s) + p;
                    ref_b[s][g*(1<<s)+p]  = g * (2 << s) + p + (1 << s);
                    ref_tw[s][g*(1<<s)+p] = p * (N / (2 << s));
                end
            end
        end

        avec[0] = '{0, 3, 6, 7, 0};
        avec[1] = '{2, 5, 9, 13, 2};
        avec[2] = '{3, 7, 7, 15, 7};
        avec[3] = '{1, 3, 5, 7, 4};
        avec[4] = '{0, 0, 0, 1, 0};
        avec[5] = '{3, 0, 0, 8, 0};

        runs[0] = '{0, 0, 0, 0, 0, 41};
        runs[1] = '{10, 5, 0, 0, 0, 46};
        runs[2] = '{3, 1, 0, 0, 1, 42};
        runs[3] = '{0, 0, 1, 2, 0, -1};
        runs[4] = '{0, 0, 1, 2, 1, -1};

        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b1;
`ifdef FFT_SCHED_INVERSE_EN
        inverse = 1'b0;
`endif
        @(posedge clk);
        #1;
        chk("rst_busy", busy, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_rd_en", rd_en, 32'd0);
        chk("rst_wr_en", wr_en, 32'd0);
        chk("rst_rd_addr_a", rd_addr_a, 32'd0);
        chk("rst_wr_addr_b", wr_addr_b, 32'd0);
        chk("rst_stage", stage, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);

        for (int i = 0; i < 5; i++) begin
            do_run(runs[i], dc, nr, nw);
            if (runs[i].exp_done >= 0) chk("done_cycle", dc, runs[i].exp_done);
            chk("rd_count", nr, 32'd32);
            chk("wr_count", nw, 32'd32);
            idle_cycles(2);
        end

        for (int i = 0; i < 6; i++) begin
            chk("vec_rd_a", obs_a[avec[i].s][avec[i].k], avec[i].a);
            chk("vec_rd_b", obs_b[avec[i].s][avec[i].k], avec[i].b);
            chk("vec_tw", obs_tw[avec[i].s][avec[i].k], avec[i].tw);
        end

        // Stray starts at 5 and 41 ignored; start at 42 begins a second run ending at 83.
        rv = '{0, 0, 0, 1, 0, 41};
        do_run(rv, d1, nr, nw);
        chk("b2b_first_done", d1, 32'd41);
        rv = '{0, 0, 0, 0, 0, 41};
        do_run(rv, d2, nr, nw);
        chk("b2b_second_done_abs", d1 + 1 + d2, 32'd83);
        idle_cycles(2);

        // Asynchronous reset in the middle of a run.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        chk("pre_rst_busy", busy, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_rd_en", rd_en, 32'd0);
        chk("mid_rst_wr_en", wr_en, 32'd0);
        chk("mid_rst_rd_addr_b", rd_addr_b, 32'd0);
        chk("mid_rst_wr_addr_a", wr_addr_a, 32'd0);
        chk("mid_rst_tw_addr", tw_addr, 32'd0);
        chk("mid_rst_stage", stage, 32'd0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            done_seen += int'(done) + int'(busy);
            @(posedge clk);
            #1;
        end
        chk("post_rst_quiet", done_seen, 32'd0);

        rv = '{0, 0, 0, 0, 0, 41};
        do_run(rv, dc, nr, nw);
        chk("recover_done", dc, 32'd41);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
